my_ep_tx_engine: RTL and testbench
==================================

Name: my_ep_tx_engine

Overview:
Downstream stage of my_ep_mem_ctrl on the endpoint transmit path. It accepts a completion request (req_compl_o/req_*_o bundle) and builds a PCIe Completion TLP:
- CplD when data is requested, Cpl otherwise.
- Payload DWs are fetched from the endpoint memory read port.
- The TLP is driven onto the 32-bit TRN transmit interface.
- When the TLP has been fully accepted, it pulses compl_done_o, which feeds the controller's txe_compl_done_i.

Parameters:
CPL_BUF_BIT, 2, index of the trn_tbuf_av_i bit that signals completion buffer space

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
req_compl_i  in  1  single-cycle completion request strobe
req_compl_with_data_i  in  1  1 = CplD, 0 = Cpl (valid with strobe)
req_tc_i  in  3  traffic class
req_td_i  in  1  TD bit
req_ep_i  in  1  EP bit
req_attr_i  in  2  attributes
req_len_i  in  10  length in DW (0 = 1024)
req_rid_i  in  16  requester ID
req_tag_i  in  8  tag
req_be_i  in  8  [3:0] first-DW BE, [7:4] last-DW BE
req_addr_i  in  13  byte address
completer_id_i  in  16  bus/dev/func of this endpoint
compl_done_o  out  1  one-cycle pulse, TLP fully sent
rd_addr_o  out  11  memory DW address
rd_be_o  out  4  memory byte enables
rd_data_i  in  32  memory read data, valid 1 clk after rd_addr_o
trn_td_o  out  32  TLP data
trn_tsof_n_o  out  1  start of frame, active-low
trn_teof_n_o  out  1  end of frame, active-low
trn_tsrc_rdy_n_o  out  1  source ready, active-low
trn_tsrc_dsc_n_o  out  1  discontinue, tied high
trn_tdst_rdy_n_i  in  1  destination ready, active-low
trn_tbuf_av_i  in  6  buffer-available vector

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - trn_td_o=0; trn_tsof_n_o, trn_teof_n_o, trn_tsrc_rdy_n_o, trn_tsrc_dsc_n_o = 1.
  - rd_addr_o=0, rd_be_o=0, compl_done_o=0.
  - Reset mid-packet abandons the TLP; no compl_done_o is issued.
- Beat transfer: occurs only on a clk edge with trn_tsrc_rdy_n_o=0 and trn_tdst_rdy_n_i=0. While stalled, all trn outputs hold stable.
- States: IDLE, WAIT_BUF, HDR0, HDR1, HDR2, DATA, DWAIT.
  - IDLE: on req_compl_i=1, latch all req_* fields, then go to WAIT_BUF. The strobe is ignored in any other state; upstream guarantees one outstanding request.
  - WAIT_BUF: advance to HDR0 when trn_tbuf_av_i[CPL_BUF_BIT]=1.
  - HDR0, HDR1, HDR2: drive the header DWs below with tsrc_rdy_n=0. tsof_n=0 on HDR0 only.
    - Cpl: teof_n=0 on HDR2, then IDLE.
    - CplD: on HDR2 accept, go to DATA.
  - DATA: trn_td_o = rd_data_i; teof_n=0 on the last DW. On accept:
    - last DW: go to IDLE;
    - otherwise: increment the DW index and go to DWAIT.
  - DWAIT: one bubble cycle with tsrc_rdy_n=1 to cover memory latency, then DATA.
- compl_done_o: pulses 1 clk in the cycle after the last beat is accepted.
- Header fields:
  - DW0 = {0, fmt(CplD 2'b10 / Cpl 2'b00), type 5'b01010, 0, tc, 4'b0, td, ep, attr, 2'b00, len}. Length field is 0 for Cpl.
  - DW1 = {completer_id_i, status 3'b000, bcm 0, byte_count[11:0]}.
  - DW2 = {rid, tag, 0, lower_addr[6:0]}.
- lower_addr = {addr[6:2], offset of the first set bit of first BE}.
  - first BE 0000 gives offset 00.
- byte_count for len=1, by first BE:
  - 1xx1 → 4
  - 01x1, 1x10 → 3
  - 0011, 0110, 1100 → 2
  - any single bit, or 0000 → 1
- byte_count for len>1: len*4 − (disabled low bytes of first BE) − (disabled high bytes of last BE).
  - len=0 means 1024 DW; 4096 truncates to 12'h000.
- Memory read port:
  - rd_addr_o = addr[12:2] + DW index (11-bit wrap). It is driven from HDR0 onward, so the first data DW is ready in DATA.
  - rd_be_o: first DW uses first BE, last DW uses last BE, middle DWs use 4'hF. A single-DW completion uses first BE.
- Internal DW counter is 11 bits.

Test Plan:
- Read, len=1: be=0F, addr=0x10, tag=5, rid=0, completer=0x0100, mem[4]=0xDEADBEEF → beats 0x4A000001, 0x01000004, 0x00000510, 0xDEADBEEF; tsof on beat 1, teof on beat 4; compl_done_o pulses once.
- Partial BE: len=1, be=0x0C, addr=0x20 → DW1[11:0]=0x002, DW2[6:0]=0x22, rd_be_o=0xC.
- Multi-DW: len=4, be=0x7E, addr=0x40 → byte_count 14, lower_addr 0x41; rd_addr_o 0x10..0x13; rd_be_o E,F,F,7; one DWAIT bubble between data beats; teof on the 4th data DW.
- Backpressure: trn_tdst_rdy_n_i=1 for 3 clks during HDR1 → trn_td_o holds DW1; no duplicated or dropped beat; total beat count unchanged.
- Buffer gating: trn_tbuf_av_i[2]=0 when the strobe arrives → no tsrc_rdy; header starts 1 clk after bit 2 rises, with the latched fields.
- Cpl without data, then reset: Cpl gives 3 beats with DW0=0x0A000000 and teof on DW2; then start a len=4 CplD and assert rst_n=0 during DATA → outputs return to reset values, no compl_done_o, next request completes normally.

Source files
------------

// File: rtl/my_ep_tx_engine.sv
// Completion TLP transmit engine: turns a latched completion request into a Cpl/CplD
// on the 32-bit TRN interface, fetching payload DWs from the endpoint memory read port.
module my_ep_tx_engine #(
    parameter int unsigned CPL_BUF_BIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_compl_i,
    input  logic        req_compl_with_data_i,
    input  logic [2:0]  req_tc_i,
    input  logic        req_td_i,
    input  logic        req_ep_i,
    input  logic [1:0]  req_attr_i,
    input  logic [9:0]  req_len_i,
    input  logic [15:0] req_rid_i,
    input  logic [7:0]  req_tag_i,
    input  logic [7:0]  req_be_i,
    input  logic [12:0] req_addr_i,
    input  logic [15:0] completer_id_i,
    output logic        compl_done_o,
    output logic [10:0] rd_addr_o,
    output logic [3:0]  rd_be_o,
    input  logic [31:0] rd_data_i,
    output logic [31:0] trn_td_o,
    output logic        trn_tsof_n_o,
    output logic        trn_teof_n_o,
    output logic        trn_tsrc_rdy_n_o,
    output logic        trn_tsrc_dsc_n_o,
    input  logic        trn_tdst_rdy_n_i,
    input  logic [5:0]  trn_tbuf_av_i
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitBuf,
        StHdr0,
        StHdr1,
        StHdr2,
        StData,
        StDwait
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_with_data;
    logic [2:0]  r_tc;
    logic        r_td;
    logic        r_ep;
    logic [1:0]  r_attr;
    logic [9:0]  r_len;
    logic [15:0] r_rid;
    logic [7:0]  r_tag;
    logic [7:0]  r_be;
    logic [10:0] r_dw_addr;
    logic [10:0] r_idx;
    logic [10:0] w_idx_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_latch;

    logic [3:0]  w_fbe;
    logic [3:0]  w_lbe;
    logic [10:0] w_len_dw;
    logic [2:0]  w_bc_single;
    logic [1:0]  w_first_skip;
    logic [1:0]  w_last_skip;
    logic [12:0] w_bc_multi;
    logic [11:0] w_byte_count;
    logic [6:0]  w_lower_addr;
    logic        w_last;
    logic [3:0]  w_rd_be;
    logic [31:0] w_dw0;
    logic [31:0] w_dw1;
    logic [31:0] w_dw2;
    logic        w_unused;

    // Address bits below DW granularity and the other buffer-class bits are not needed.
    assign w_unused = ^{req_addr_i[1:0], trn_tbuf_av_i};

    always_comb begin
        w_fbe    = r_be[3:0];
        w_lbe    = r_be[7:4];
        w_len_dw = (r_len == 10'd0) ? 11'd1024 : {1'b0, r_len};

        casez (w_fbe)
            4'b1??1: w_bc_single = 3'd4;
            4'b01?1: w_bc_single = 3'd3;
            4'b1?10: w_bc_single = 3'd3;
            4'b0011: w_bc_single = 3'd2;
            4'b0110: w_bc_single = 3'd2;
            4'b1100: w_bc_single = 3'd2;
            default: w_bc_single = 3'd1;
        endcase

        // Disabled bytes below the first enabled one; doubles as the lower-address offset.
        casez (w_fbe)
            4'b???1: w_first_skip = 2'd0;
            4'b??10: w_first_skip = 2'd1;
            4'b?100: w_first_skip = 2'd2;
            4'b1000: w_first_skip = 2'd3;
            default: w_first_skip = 2'd0;
        endcase

        casez (w_lbe)
            4'b1???: w_last_skip = 2'd0;
            4'b01??: w_last_skip = 2'd1;
            4'b001?: w_last_skip = 2'd2;
            4'b0001: w_last_skip = 2'd3;
            default: w_last_skip = 2'd0;
        endcase

        w_bc_multi   = {w_len_dw, 2'b00} - {11'd0, w_first_skip} - {11'd0, w_last_skip};
        w_byte_count = (w_len_dw == 11'd1) ? {9'd0, w_bc_single} : w_bc_multi[11:0];
        w_lower_addr = {r_dw_addr[4:0], w_first_skip};

        w_last  = (r_idx == (w_len_dw - 11'd1));
        w_rd_be = (r_idx == 11'd0) ? w_fbe : (w_last ? w_lbe : 4'hF);

        w_dw0 = {1'b0, (r_with_data ? 2'b10 : 2'b00), 5'b01010, 1'b0, r_tc, 4'b0000,
                 r_td, r_ep, r_attr, 2'b00, (r_with_data ? r_len : 10'd0)};
        w_dw1 = {completer_id_i, 3'b000, 1'b0, w_byte_count};
        w_dw2 = {r_rid, r_tag, 1'b0, w_lower_addr};
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_done_nxt       = 1'b0;
        w_latch          = 1'b0;
        trn_td_o         = 32'd0;
        trn_tsof_n_o     = 1'b1;
        trn_teof_n_o     = 1'b1;
        trn_tsrc_rdy_n_o = 1'b1;
        rd_addr_o        = 11'd0;
        rd_be_o          = 4'd0;

        // Address the current DW from HDR0 on so synchronous read data is ready by DATA.
        if (r_state != StIdle && r_state != StWaitBuf) begin
            rd_addr_o = r_dw_addr + r_idx;
            rd_be_o   = w_rd_be;
        end

        case (r_state)
            StIdle: begin
                if (req_compl_i) begin
                    w_latch     = 1'b1;
                    w_idx_nxt   = 11'd0;
                    w_state_nxt = StWaitBuf;
                end
            end
            StWaitBuf: begin
                if (trn_tbuf_av_i[CPL_BUF_BIT]) w_state_nxt = StHdr0;
            end
            StHdr0: begin
                trn_td_o         = w_dw0;
                trn_tsof_n_o     = 1'b0;
                trn_tsrc_rdy_n_o = 1'b0;
                if (!trn_tdst_rdy_n_i) w_state_nxt = StHdr1;
            end
            StHdr1: begin
                trn_td_o         = w_dw1;
                trn_tsrc_rdy_n_o = 1'b0;
                if (!trn_tdst_rdy_n_i) w_state_nxt = StHdr2;
            end
            StHdr2: begin
                trn_td_o         = w_dw2;
                trn_tsrc_rdy_n_o = 1'b0;
                trn_teof_n_o     = r_with_data;
                if (!trn_tdst_rdy_n_i) begin
                    if (r_with_data) begin
                        w_state_nxt = StData;
                    end else begin
                        w_state_nxt = StIdle;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            StData: begin
                trn_td_o         = rd_data_i;
                trn_tsrc_rdy_n_o = 1'b0;
                trn_teof_n_o     = !w_last;
                if (!trn_tdst_rdy_n_i) begin
                    if (w_last) begin
                        w_state_nxt = StIdle;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + 11'd1;
                        w_state_nxt = StDwait;
                    end
                end
            end
            StDwait: begin
                w_state_nxt = StData;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_idx       <= 11'd0;
            r_done      <= 1'b0;
            r_with_data <= 1'b0;
            r_tc        <= 3'd0;
            r_td        <= 1'b0;
            r_ep        <= 1'b0;
            r_attr      <= 2'd0;
            r_len       <= 10'd0;
            r_rid       <= 16'd0;
            r_tag       <= 8'd0;
            r_be        <= 8'd0;
            r_dw_addr   <= 11'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) begin
                r_with_data <= req_compl_with_data_i;
                r_tc        <= req_tc_i;
                r_td        <= req_td_i;
                r_ep        <= req_ep_i;
                r_attr      <= req_attr_i;
                r_len       <= req_len_i;
                r_rid       <= req_rid_i;
                r_tag       <= req_tag_i;
                r_be        <= req_be_i;
                r_dw_addr   <= req_addr_i[12:2];
            end
        end
    end

    assign compl_done_o     = r_done;
    assign trn_tsrc_dsc_n_o = 1'b1;

endmodule

// File: tb/tb_my_ep_tx_engine.sv
// Directed bench for my_ep_tx_engine: expected beats are queued when a request is issued
// and compared as the TRN interface presents them; memory is a synchronous-read model.
module tb_my_ep_tx_engine;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
        logic        is_data;
        logic [10:0] addr;
        logic [3:0]  be;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_compl;
    logic        req_wd;
    logic [2:0]  req_tc;
    logic        req_td;
    logic        req_ep;
    logic [1:0]  req_attr;
    logic [9:0]  req_len;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [7:0]  req_be;
    logic [12:0] req_addr;
    logic [15:0] cid;
    logic        compl_done;
    logic [10:0] rd_addr;
    logic [3:0]  rd_be;
    logic [31:0] rd_data;
    logic [31:0] td;
    logic        tsof_n;
    logic        teof_n;
    logic        src_rdy_n;
    logic        dsc_n;
    logic        dst_rdy_n;
    logic [5:0]  tbuf;

    logic [31:0] mem [2048];
    beat_t       sb [$];
    logic [31:0] cap [$];
    beat_t       mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          beats_acc = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    logic        pend_done = 1'b0;
    logic        bubble = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    my_ep_tx_engine #(.CPL_BUF_BIT(2)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_compl_i           (req_compl),
        .req_compl_with_data_i (req_wd),
        .req_tc_i              (req_tc),
        .req_td_i              (req_td),
        .req_ep_i              (req_ep),
        .req_attr_i            (req_attr),
        .req_len_i             (req_len),
        .req_rid_i             (req_rid),
        .req_tag_i             (req_tag),
        .req_be_i              (req_be),
        .req_addr_i            (req_addr),
        .completer_id_i        (cid),
        .compl_done_o          (compl_done),
        .rd_addr_o             (rd_addr),
        .rd_be_o               (rd_be),
        .rd_data_i             (rd_data),
        .trn_td_o              (td),
        .trn_tsof_n_o          (tsof_n),
        .trn_teof_n_o          (teof_n),
        .trn_tsrc_rdy_n_o      (src_rdy_n),
        .trn_tsrc_dsc_n_o      (dsc_n),
        .trn_tdst_rdy_n_i      (dst_rdy_n),
        .trn_tbuf_av_i         (tbuf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte count from the span of enabled bytes (single DW) or trimmed total (multi DW).
    function automatic logic [11:0] exp_bc(input logic [9:0] len, input logic [7:0] be);
        int n;
        int lo;
        int hi;
        int dl;
        int dh;
        int tot;
        n  = (len == 10'd0) ? 1024 : int'(len);
        lo = -1;
        hi = -1;
        dl = 0;
        dh = 0;
        if (n == 1) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    if (lo < 0) lo = i;
                    hi = i;
                end
            end
            tot = (lo < 0) ? 1 : hi - lo + 1;
        end else begin
            if (be[3:0] != 4'd0) for (int i = 0; i < 4 && !be[i]; i++) dl++;
            if (be[7:4] != 4'd0) for (int i = 7; i > 3 && !be[i]; i--) dh++;
            tot = n * 4 - dl - dh;
        end
        return tot[11:0];
    endfunction

    function automatic logic [6:0] exp_la(input logic [12:0] addr, input logic [7:0] be);
        logic [1:0] off;
        off = 2'd0;
        for (int i = 3; i >= 0; i--) if (be[i]) off = 2'(i);
        return {addr[6:2], off};
    endfunction

    task automatic issue(input logic wd, input logic [2:0] tc, input logic tdb, input logic ep,
                         input logic [1:0] attr, input logic [9:0] len, input logic [15:0] rid,
                         input logic [7:0] tag, input logic [7:0] be, input logic [12:0] addr);
        beat_t       b;
        int          n;
        logic [10:0] a;
        n = (len == 10'd0) ? 1024 : int'(len);
        b = '0;
        b.data = {1'b0, (wd ? 2'b10 : 2'b00), 5'b01010, 1'b0, tc, 4'b0000, tdb, ep, attr, 2'b00,
                  (wd ? len : 10'd0)};
        b.sof = 1'b1;
        sb.push_back(b);
        b.sof  = 1'b0;
        b.data = {cid, 4'b0000, exp_bc(len, be)};
        sb.push_back(b);
        b.data = {rid, tag, 1'b0, exp_la(addr, be)};
        b.eof  = !wd;
        sb.push_back(b);
        if (wd) begin
            for (int k = 0; k < n; k++) begin
                a         = addr[12:2] + 11'(k);
                b.data    = mem[a];
                b.is_data = 1'b1;
                b.addr    = a;
                b.be      = (k == 0) ? be[3:0] : ((k == n - 1) ? be[7:4] : 4'hF);
                b.eof     = (k == n - 1);
                sb.push_back(b);
            end
        end
        exp_done++;
        req_wd = wd; req_tc = tc; req_td = tdb; req_ep = ep; req_attr = attr; req_len = len;
        req_rid = rid; req_tag = tag; req_be = be; req_addr = addr; req_compl = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the bundle so any use of unlatched fields shows up.
        req_compl = 1'b0; req_wd = ~wd; req_tc = ~tc; req_len = ~len; req_rid = ~rid;
        req_tag = ~tag; req_be = ~be; req_addr = ~addr; req_attr = ~attr;
    endtask

    task automatic drain(input string tag, input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    endtask

    task automatic wait_beats(input int target, input int budget);
        int t;
        t = 0;
        while (beats_acc < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        check("wait_beats", 32'(beats_acc), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_td"}, td, 32'd0);
        check({tag, "_flags"}, {28'd0, tsof_n, teof_n, src_rdy_n, dsc_n}, 32'hF);
        check({tag, "_rd"}, {17'd0, rd_addr, rd_be}, 32'd0);
        check({tag, "_done"}, {31'd0, compl_done}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            pend_done = 1'b0;
            bubble    = 1'b0;
        end else begin
            if (compl_done) done_cnt++;
            check("compl_done", {31'd0, compl_done}, {31'd0, pend_done});
            pend_done = 1'b0;
            if (bubble) check("dwait_bubble", {31'd0, src_rdy_n}, 32'd1);
            bubble = 1'b0;
            if (sb.size() == 0) begin
                check("idle_src_rdy", {31'd0, src_rdy_n}, 32'd1);
            end else if (!src_rdy_n) begin
                mon_e = sb[0];
                check("beat_td", td, mon_e.data);
                check("beat_sof_eof", {30'd0, tsof_n, teof_n}, {30'd0, !mon_e.sof, !mon_e.eof});
                if (mon_e.is_data) check("rd_port", {17'd0, rd_addr, rd_be},
                                         {17'd0, mon_e.addr, mon_e.be});
                if (!dst_rdy_n) begin
                    void'(sb.pop_front());
                    cap.push_back(td);
                    beats_acc++;
                    if (mon_e.eof) pend_done = 1'b1;
                    else if (mon_e.is_data) bubble = 1'b1;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: run exceeded time limit, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int c0;
        for (int i = 0; i < 2048; i++) mem[i] = {16'(i) ^ 16'h5A5A, ~16'(i)};
        mem[4] = 32'hDEADBEEF;
        req_compl = 1'b0; req_wd = 1'b0; req_tc = '0; req_td = 1'b0; req_ep = 1'b0;
        req_attr = '0; req_len = '0; req_rid = '0; req_tag = '0; req_be = '0; req_addr = '0;
        cid = 16'h0100; dst_rdy_n = 1'b0; tbuf = 6'h3F;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-DW read, full first BE.
        c0 = cap.size();
        issue(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0000, 8'h05, 8'h0F, 13'h0010);
        drain("read1", 50);
        check("read1_dw0", cap[c0], 32'h4A000001);
        check("read1_dw1", cap[c0+1], 32'h01000004);
        check("read1_dw2", cap[c0+2], 32'h00000510);
        check("read1_data", cap[c0+3], 32'hDEADBEEF);

        // Partial BE.
        c0 = cap.size();
        issue(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0000, 8'h06, 8'h0C, 13'h0020);
        drain("partial", 50);
        check("partial_bc", {20'd0, cap[c0+1][11:0]}, 32'h002);
        check("partial_la", {25'd0, cap[c0+2][6:0]}, 32'h22);

        // Multi-DW with trimmed first/last BE and non-zero header fields.
        issue(1'b1, 3'd5, 1'b1, 1'b1, 2'd2, 10'd4, 16'hBEEF, 8'h3C, 8'h7E, 13'h0040);
        drain("multi", 80);

        // Backpressure during HDR1.
        b0 = beats_acc;
        issue(1'b1, 3'd1, 1'b0, 1'b0, 2'd1, 10'd2, 16'h1234, 8'h11, 8'hFF, 13'h0100);
        wait_beats(b0 + 1, 20);
        #1;
        dst_rdy_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_hold", td, {cid, 4'b0000, 12'd8});
        end
        dst_rdy_n = 1'b0;
        drain("stall", 50);
        check("stall_beats", 32'(beats_acc), 32'(b0 + 5));

        // Buffer gating on bit 2 only.
        tbuf = 6'h3B;
        issue(1'b1, 3'd2, 1'b0, 1'b0, 2'd0, 10'd1, 16'h00AA, 8'h22, 8'h01, 13'h0804);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("gate_hold", {31'd0, src_rdy_n}, 32'd1);
        end
        tbuf = 6'h3F;
        @(posedge clk);
        #1;
        check("gate_start", {30'd0, src_rdy_n, tsof_n}, 32'd0);
        drain("gate", 50);

        // Completion without data.
        c0 = cap.size();
        issue(1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0000, 8'h07, 8'h0F, 13'h0010);
        drain("cpl", 50);
        check("cpl_dw0", cap[c0], 32'h0A000000);
        check("cpl_beats", 32'(cap.size() - c0), 32'd3);

        // Reset in the middle of a CplD data phase.
        b0 = beats_acc;
        issue(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 10'd4, 16'h0001, 8'h44, 8'hFF, 13'h0080);
        wait_beats(b0 + 3, 20);
        #1;
        rst_n = 1'b0;
        sb.delete();
        exp_done--;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done_cnt), 32'(exp_done));

        // Normal request after reset; DW address wraps past 0x7FF.
        issue(1'b1, 3'd7, 1'b0, 1'b1, 2'd3, 10'd3, 16'hCAFE, 8'h99, 8'h3F, 13'h1FF8);
        drain("wrap", 50);

        // len=0 means 1024 DWs; byte count truncates to zero.
        c0 = cap.size();
        issue(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 10'd0, 16'h0002, 8'h55, 8'hFF, 13'h0000);
        drain("len1024", 4000);
        check("len1024_bc", {20'd0, cap[c0+1][11:0]}, 32'h000);
        check("len1024_beats", 32'(cap.size() - c0), 32'd1027);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
